// File: rtl/cordic_lut_pkg.sv
// CORDIC angle tables (circular atan, hyperbolic atanh) in IEEE-754
// double and single precision, plus sequencer state and mode constants.
package cordic_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_FINISH
    } state_e;

    localparam logic MODE_CIRC = 1'b0;
    localparam logic MODE_HYP  = 1'b1;

    localparam int HYP_REP0 = 4;
    localparam int HYP_REP1 = 13;
    localparam int TAB_N    = 32;

    function automatic logic [63:0] atan_d(input int i);
        real x;
        x = 1.0;
        for (int k = 0; k < i; k++) x = x / 2.0;
        return $realtobits($atan(x));
    endfunction

    function automatic logic [63:0] atanh_d(input int i);
        real x;
        x = 1.0;
        for (int k = 0; k < i; k++) x = x / 2.0;
        if (i == 0) return 64'h0;
        return $realtobits($atanh(x));
    endfunction

    // Narrow a normal double to single, round to nearest-even.
    function automatic logic [31:0] d2s(input logic [63:0] d);
        logic [24:0] man;
        logic [28:0] rem;
        logic [10:0] se;
        if (d[62:0] == 63'h0) return 32'h0;
        man = {2'b01, d[51:29]};
        rem = d[28:0];
        se  = d[62:52] - 11'd896;
        if (rem > 29'h1000_0000 ||
            (rem == 29'h1000_0000 && man[0])) begin
            man = man + 25'd1;
        end
        if (man[24]) begin
            man = man >> 1;
            se  = se + 11'd1;
        end
        return {d[63], se[7:0], man[22:0]};
    endfunction

    function automatic logic [31:0] atan_s(input int i);
        return d2s(atan_d(i));
    endfunction

    function automatic logic [31:0] atanh_s(input int i);
        return d2s(atanh_d(i));
    endfunction

    localparam logic [63:0] ATAN_D [TAB_N] = '{
        atan_d(0),  atan_d(1),  atan_d(2),  atan_d(3),
        atan_d(4),  atan_d(5),  atan_d(6),  atan_d(7),
        atan_d(8),  atan_d(9),  atan_d(10), atan_d(11),
        atan_d(12), atan_d(13), atan_d(14), atan_d(15),
        atan_d(16), atan_d(17), atan_d(18), atan_d(19),
        atan_d(20), atan_d(21), atan_d(22), atan_d(23),
        atan_d(24), atan_d(25), atan_d(26), atan_d(27),
        atan_d(28), atan_d(29), atan_d(30), atan_d(31)
    };

    localparam logic [31:0] ATAN_S [TAB_N] = '{
        atan_s(0),  atan_s(1),  atan_s(2),  atan_s(3),
        atan_s(4),  atan_s(5),  atan_s(6),  atan_s(7),
        atan_s(8),  atan_s(9),  atan_s(10), atan_s(11),
        atan_s(12), atan_s(13), atan_s(14), atan_s(15),
        atan_s(16), atan_s(17), atan_s(18), atan_s(19),
        atan_s(20), atan_s(21), atan_s(22), atan_s(23),
        atan_s(24), atan_s(25), atan_s(26), atan_s(27),
        atan_s(28), atan_s(29), atan_s(30), atan_s(31)
    };

    localparam logic [63:0] ATANH_D [TAB_N] = '{
        atanh_d(0),  atanh_d(1),  atanh_d(2),  atanh_d(3),
        atanh_d(4),  atanh_d(5),  atanh_d(6),  atanh_d(7),
        atanh_d(8),  atanh_d(9),  atanh_d(10), atanh_d(11),
        atanh_d(12), atanh_d(13), atanh_d(14), atanh_d(15),
        atanh_d(16), atanh_d(17), atanh_d(18), atanh_d(19),
        atanh_d(20), atanh_d(21), atanh_d(22), atanh_d(23),
        atanh_d(24), atanh_d(25), atanh_d(26), atanh_d(27),
        atanh_d(28), atanh_d(29), atanh_d(30), atanh_d(31)
    };

    localparam logic [31:0] ATANH_S [TAB_N] = '{
        atanh_s(0),  atanh_s(1),  atanh_s(2),  atanh_s(3),
        atanh_s(4),  atanh_s(5),  atanh_s(6),  atanh_s(7),
        atanh_s(8),  atanh_s(9),  atanh_s(10), atanh_s(11),
        atanh_s(12), atanh_s(13), atanh_s(14), atanh_s(15),
        atanh_s(16), atanh_s(17), atanh_s(18), atanh_s(19),
        atanh_s(20), atanh_s(21), atanh_s(22), atanh_s(23),
        atanh_s(24), atanh_s(25), atanh_s(26), atanh_s(27),
        atanh_s(28), atanh_s(29), atanh_s(30), atanh_s(31)
    };

endpackage

// File: rtl/cordic_angle_rom.sv
// Registered angle ROM: table chosen by word width and mode.
// No reset; the parent zeroes its own output register.
module cordic_angle_rom
    import cordic_lut_pkg::*;
#(
    parameter int W    = 64,
    parameter int IDXW = 5
) (
    input  logic            clk,
    input  logic            en,
    input  logic            mode,
    input  logic [IDXW-1:0] addr,
    output logic [W-1:0]    data
);

    logic [4:0]   a;
    logic [W-1:0] word;

    assign a = 5'(addr);

    if (W == 64) begin : g_dbl
        always_comb word = (mode == MODE_HYP) ? ATANH_D[a] : ATAN_D[a];
    end else begin : g_sgl
        always_comb word = (mode == MODE_HYP) ? ATANH_S[a] : ATAN_S[a];
    end

    always_ff @(posedge clk) begin
        if (en) data <= word;
    end

endmodule

// File: rtl/cordic_atan_lut_seq.sv
// CORDIC angle-constant sequencer: walks the iteration indices for the
// selected mode and presents one angle per valid/ready beat.
module cordic_atan_lut_seq
    import cordic_lut_pkg::*;
#(
    parameter int W     = 64,
    parameter int ITERS = 32,
    parameter int IDXW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic            abort,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    data_out,
    output logic [IDXW-1:0] iter_idx,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    if (W != 32 && W != 64) begin : g_bad_w
        $error("cordic_atan_lut_seq: W must be 32 or 64");
    end
    if (ITERS < 4 || ITERS > TAB_N) begin : g_bad_iters
        $error("cordic_atan_lut_seq: ITERS must be 4..32");
    end
    if ((2 ** IDXW) < ITERS) begin : g_bad_idxw
        $error("cordic_atan_lut_seq: IDXW too narrow for ITERS");
    end

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            rep_q, rep_d;
    logic [W-1:0]    data_q, data_d;
    logic [W-1:0]    rom_data;
    logic            rom_en;
    logic            is_rep;
    logic            rep_pend;
    logic            is_last;

    assign is_rep   = (32'(idx_q) == HYP_REP0) ||
                      (32'(idx_q) == HYP_REP1);
    assign rep_pend = (mode_q == MODE_HYP) && is_rep && !rep_q;
    assign is_last  = (32'(idx_q) == ITERS - 1) && !rep_pend;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        data_d  = data_q;
        if (state_q == ST_FETCH) data_d = rom_data;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d  = mode;
                        idx_d   = (mode == MODE_HYP) ? IDXW'(1) : '0;
                        rep_d   = 1'b0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: state_d = ST_PRESENT;
                ST_PRESENT: begin
                    if (out_ready) begin
                        if (is_last) begin
                            state_d = ST_FINISH;
                        end else begin
                            // A pending repeat re-issues the same index once.
                            if (rep_pend) begin
                                rep_d = 1'b1;
                            end else begin
                                idx_d = idx_q + 1'b1;
                                rep_d = 1'b0;
                            end
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_FINISH: state_d = ST_IDLE;
            endcase
        end
    end

    assign rom_en = (state_d == ST_FETCH);

    cordic_angle_rom #(
        .W    (W),
        .IDXW (IDXW)
    ) u_rom (
        .clk  (clk),
        .en   (rom_en),
        .mode (mode_d),
        .addr (idx_d),
        .data (rom_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_CIRC;
            idx_q   <= '0;
            rep_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == ST_PRESENT);
    assign out_last  = out_valid && is_last;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);
    assign data_out  = data_q;
    assign iter_idx  = idx_q;

endmodule

// File: tb/tb_cordic_atan_lut_seq.sv
// Bench for cordic_atan_lut_seq: double and single instances share stimulus
// and are checked against a real-arithmetic reference of the angle tables.
module tb_cordic_atan_lut_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, mode = 1'b0, abort = 1'b0, out_ready = 1'b0;

    logic        v64, l64, b64, dn64;
    logic [63:0] d64;
    logic [4:0]  i64;
    logic        v32, l32, b32, dn32;
    logic [31:0] d32;
    logic [4:0]  i32;

    int checks = 0;
    int errors = 0;

    int          obs_idx[$];
    logic [63:0] obs_d64[$];
    logic [31:0] obs_d32[$];
    bit          obs_last[$];
    int          exp_idx[$];

    int nb, viol, gap;
    bit dn_a, bz_a, tmo;

    cordic_atan_lut_seq #(.W(64), .ITERS(32), .IDXW(5)) dut64 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .out_valid(v64), .out_ready(out_ready), .data_out(d64),
        .iter_idx(i64), .out_last(l64), .busy(b64), .done(dn64)
    );

    cordic_atan_lut_seq #(.W(32), .ITERS(32), .IDXW(5)) dut32 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .out_valid(v32), .out_ready(out_ready), .data_out(d32),
        .iter_idx(i32), .out_last(l32), .busy(b32), .done(dn32)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_d(input bit m, input int i);
        real x;
        if (m && i == 0) return 64'h0;
        x = 1.0;
        for (int k = 0; k < i; k++) x = x / 2.0;
        return m ? $realtobits($atanh(x)) : $realtobits($atan(x));
    endfunction

    function automatic logic [31:0] ref_s(input bit m, input int i);
        real v, mm, f;
        int e;
        longint q;
        logic [63:0] qb;
        if (m && i == 0) return 32'h0;
        v = $bitstoreal(ref_d(m, i));
        e = 0;
        while (v < 1.0) begin v = v * 2.0; e--; end
        mm = v * 8388608.0;
        f  = $floor(mm);
        q  = longint'(f);
        if ((mm - f) > 0.5 || ((mm - f) == 0.5 && (q % 2) == 1)) q++;
        if (q == 64'd16777216) begin q = 8388608; e++; end
        qb = 64'(q);
        return {1'b0, 8'(e + 127), qb[22:0]};
    endfunction

    task automatic build_exp(input bit m);
        exp_idx.delete();
        if (!m) begin
            for (int i = 0; i < 32; i++) exp_idx.push_back(i);
        end else begin
            for (int i = 1; i < 32; i++) begin
                exp_idx.push_back(i);
                if (i == 4 || i == 13) exp_idx.push_back(i);
            end
        end
    endtask

    task automatic run_seq(input bit m, input int pct, input bit spam,
                           output int nb_o, output int viol_o,
                           output int gap_o, output bit dn_o,
                           output bit bz_o, output bit tmo_o);
        bit pend, rdy;
        logic [63:0] pd;
        logic [31:0] ps;
        logic [4:0]  pi;
        bit pl;
        int last_acc;
        obs_idx.delete(); obs_d64.delete();
        obs_d32.delete(); obs_last.delete();
        nb_o = 0; viol_o = 0; gap_o = -1; dn_o = 0; bz_o = 0; tmo_o = 1;
        pend = 0; pd = '0; ps = '0; pi = '0; pl = 0; last_acc = -100;
        @(negedge clk); start = 1'b1; mode = m; out_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (pend && !(v64 === 1'b1 && d64 === pd && d32 === ps &&
                          i64 === pi && l64 === pl)) viol_o++;
            if (v32 !== v64 || i32 !== i64 || l32 !== l64 ||
                b32 !== b64 || dn32 !== dn64) viol_o++;
            if (dn64 === 1'b1) begin
                gap_o = cyc - last_acc;
                tmo_o = 0;
                break;
            end
            rdy = ($urandom_range(99) < pct);
            out_ready = rdy;
            if (spam) start = 1'($urandom_range(1));
            pend = 0;
            if (v64 === 1'b1 && rdy) begin
                obs_idx.push_back(int'(i64));
                obs_d64.push_back(d64);
                obs_d32.push_back(d32);
                obs_last.push_back(l64);
                nb_o++;
                last_acc = cyc;
            end else if (v64 === 1'b1) begin
                pend = 1; pd = d64; ps = d32; pi = i64; pl = l64;
            end
            @(negedge clk);
        end
        start = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        dn_o = dn64;
        bz_o = b64;
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({v64, l64, b64, dn64, d64, i64} !== '0) begin
            errors++;
            $display("FAIL reset64 got v%b l%b b%b d%b data %h idx %0d want all 0",
                     v64, l64, b64, dn64, d64, i64);
        end
        checks++;
        if ({v32, l32, b32, dn32, d32, i32} !== '0) begin
            errors++;
            $display("FAIL reset32 got v%b b%b data %h idx %0d want all 0",
                     v32, b32, d32, i32);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({v64, b64, dn64, d64, i64} !== '0) begin
            errors++;
            $display("FAIL reset_hold got v%b b%b data %h want 0", v64, b64, d64);
        end
        rst = 1'b1;
    endtask

    task automatic test_circular;
        run_seq(1'b0, 100, 1'b0, nb, viol, gap, dn_a, bz_a, tmo);
        build_exp(1'b0);
        checks++;
        if (tmo || nb !== 32) begin
            errors++;
            $display("FAIL circ_count got %0d (timeout %0d) want 32", nb, tmo);
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL circ_stable got %0d violations want 0", viol);
        end
        checks++;
        if (gap !== 1 || dn_a !== 1'b0 || bz_a !== 1'b0) begin
            errors++;
            $display("FAIL circ_done gap %0d after %b busy %b want 1 0 0",
                     gap, dn_a, bz_a);
        end
        checks++;
        if (obs_d64[0] !== 64'h3fe921fb54442d18 ||
            obs_d64[1] !== 64'h3fddac670561bb4f ||
            obs_d64[31] !== 64'h3e00000000000000) begin
            errors++;
            $display("FAIL circ_consts got %h %h %h want 3fe921fb54442d18 3fddac670561bb4f 3e00000000000000",
                     obs_d64[0], obs_d64[1], obs_d64[31]);
        end
        for (int k = 0; k < obs_idx.size(); k++) begin
            int ei;
            ei = (k < exp_idx.size()) ? exp_idx[k] : -1;
            checks++;
            if (obs_idx[k] !== ei || obs_d64[k] !== ref_d(0, ei) ||
                obs_d32[k] !== ref_s(0, ei) ||
                obs_last[k] !== (k == exp_idx.size() - 1)) begin
                errors++;
                $display("FAIL circ_beat %0d idx %0d/%0d d64 %h/%h d32 %h/%h last %0d/%0d",
                         k, obs_idx[k], ei, obs_d64[k], ref_d(0, ei),
                         obs_d32[k], ref_s(0, ei), obs_last[k],
                         (k == exp_idx.size() - 1));
            end
        end
    endtask

    task automatic test_hyperbolic;
        run_seq(1'b1, 100, 1'b0, nb, viol, gap, dn_a, bz_a, tmo);
        build_exp(1'b1);
        checks++;
        if (tmo || nb !== 33) begin
            errors++;
            $display("FAIL hyp_count got %0d (timeout %0d) want 33", nb, tmo);
        end
        checks++;
        if (viol !== 0 || gap !== 1 || dn_a !== 1'b0) begin
            errors++;
            $display("FAIL hyp_done viol %0d gap %0d after %b want 0 1 0",
                     viol, gap, dn_a);
        end
        checks++;
        if (obs_idx[3] !== 4 || obs_idx[4] !== 4 ||
            obs_d64[3] !== ref_d(1, 4) || obs_d64[4] !== ref_d(1, 4)) begin
            errors++;
            $display("FAIL hyp_repeat4 idx %0d %0d data %h %h want 4 4 %h",
                     obs_idx[3], obs_idx[4], obs_d64[3], obs_d64[4], ref_d(1, 4));
        end
        for (int k = 0; k < obs_idx.size(); k++) begin
            int ei;
            ei = (k < exp_idx.size()) ? exp_idx[k] : -1;
            checks++;
            if (obs_idx[k] !== ei || obs_d64[k] !== ref_d(1, ei) ||
                obs_d32[k] !== ref_s(1, ei) ||
                obs_last[k] !== (k == exp_idx.size() - 1)) begin
                errors++;
                $display("FAIL hyp_beat %0d idx %0d/%0d d64 %h/%h d32 %h/%h last %0d",
                         k, obs_idx[k], ei, obs_d64[k], ref_d(1, ei),
                         obs_d32[k], ref_s(1, ei), obs_last[k]);
            end
        end
    endtask

    task automatic test_random_ready;
        for (int r = 0; r < 2; r++) begin
            bit m;
            int bad;
            m = (r == 1);
            run_seq(m, 45, 1'b0, nb, viol, gap, dn_a, bz_a, tmo);
            build_exp(m);
            checks++;
            if (tmo || nb !== exp_idx.size() || viol !== 0) begin
                errors++;
                $display("FAIL rand_ready m%0d count %0d want %0d viol %0d want 0",
                         m, nb, exp_idx.size(), viol);
            end
            bad = 0;
            for (int k = 0; k < obs_idx.size(); k++) begin
                int ei;
                ei = (k < exp_idx.size()) ? exp_idx[k] : -1;
                if (obs_idx[k] !== ei || obs_d32[k] !== ref_s(m, ei)) bad++;
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL rand_beats m%0d got %0d bad beats want 0", m, bad);
            end
        end
        checks++;
        if (obs_d32.size() == 0 || ref_s(0, 0) !== 32'h3f490fdb) begin
            errors++;
            $display("FAIL single_ref got %h want 3f490fdb", ref_s(0, 0));
        end
        run_seq(1'b0, 60, 1'b0, nb, viol, gap, dn_a, bz_a, tmo);
        checks++;
        if (obs_d32[0] !== 32'h3f490fdb || nb !== 32) begin
            errors++;
            $display("FAIL single_first got %h count %0d want 3f490fdb 32",
                     obs_d32[0], nb);
        end
    endtask

    task automatic test_start_busy;
        int bad;
        run_seq(1'b0, 70, 1'b1, nb, viol, gap, dn_a, bz_a, tmo);
        build_exp(1'b0);
        bad = 0;
        for (int k = 0; k < obs_idx.size(); k++) begin
            if (k >= exp_idx.size() || obs_idx[k] !== exp_idx[k]) bad++;
        end
        checks++;
        if (tmo || nb !== 32 || bad !== 0 || viol !== 0) begin
            errors++;
            $display("FAIL start_busy count %0d bad %0d viol %0d want 32 0 0",
                     nb, bad, viol);
        end
    endtask

    task automatic test_abort;
        int seen, bad;
        bit hit;
        @(negedge clk); start = 1'b1; mode = 1'b0; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0; hit = 0;
        for (int c = 0; c < 200; c++) begin
            if (v64 === 1'b1) begin
                if (seen == 4) begin hit = 1; break; end
                seen++;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit || i64 !== 5'd4) begin
            errors++;
            $display("FAIL abort_beat5 reached %0d idx %0d want 1 4", hit, i64);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        checks++;
        if (v64 !== 1'b0 || b64 !== 1'b0 || dn64 !== 1'b0 ||
            v32 !== 1'b0 || b32 !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got v%b b%b done %b want 0 0 0", v64, b64, dn64);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (dn64 !== 1'b0 || b64 !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_nodone got %0d bad cycles want 0", bad);
        end
        run_seq(1'b0, 100, 1'b0, nb, viol, gap, dn_a, bz_a, tmo);
        checks++;
        if (obs_idx[0] !== 0 || obs_d64[0] !== 64'h3fe921fb54442d18 || nb !== 32) begin
            errors++;
            $display("FAIL abort_restart idx %0d data %h count %0d want 0 3fe921fb54442d18 32",
                     obs_idx[0], obs_d64[0], nb);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk); start = 1'b1; mode = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (b64 !== 1'b1 || v64 !== 1'b0) begin
            errors++;
            $display("FAIL areset_fetch got busy %b valid %b want 1 0", b64, v64);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({v64, l64, b64, dn64, d64, i64} !== '0 ||
            {v32, l32, b32, dn32, d32, i32} !== '0) begin
            errors++;
            $display("FAIL areset_now got v%b b%b data %h idx %0d data32 %h want 0",
                     v64, b64, d64, i64, d32);
        end
        @(negedge clk);
        rst = 1'b1;
        run_seq(1'b1, 100, 1'b0, nb, viol, gap, dn_a, bz_a, tmo);
        checks++;
        if (tmo || nb !== 33 || obs_idx[0] !== 1) begin
            errors++;
            $display("FAIL areset_resume count %0d first %0d want 33 1", nb, obs_idx[0]);
        end
    endtask

    task automatic test_start_abort_idle;
        int bad;
        @(negedge clk); start = 1'b1; abort = 1'b1; mode = 1'b0;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        bad = 0;
        repeat (3) begin
            if (b64 !== 1'b0 || v64 !== 1'b0 || b32 !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL start_abort_idle got %0d busy cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_circular();
        test_hyperbolic();
        test_random_ready();
        test_start_busy();
        test_abort();
        test_async_reset();
        test_start_abort_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_atan_lut_seq.md
Name: cordic_atan_lut_seq

Overview:
- Parametrised successor to the CORDIC arctangent ROM.
- Holds IEEE-754 angle tables for two modes: circular atan(2^-i) and hyperbolic atanh(2^-i). Supports single (W=32) or double (W=64) precision.
- Contains its own iteration sequencer, so the CORDIC datapath only handshakes beat-by-beat: it receives the angle constant and the shift index for each micro-rotation.
- Sits between the CORDIC control FSM and the add/subtract angle-accumulator stage.

Parameters:
- W, 64, word width; only 32 or 64 legal, any other value is an elaboration error.
- ITERS, 32, number of distinct iteration indices, range 4..32.
- IDXW, 5, width of the shift-index output; must satisfy 2^IDXW >= ITERS.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to begin a sequence; ignored unless in IDLE.
- mode, in, 1, 0 = circular, 1 = hyperbolic; sampled on accepted start.
- abort, in, 1, synchronous return to IDLE from any state.
- out_valid, out, 1, data_out and iter_idx are valid.
- out_ready, in, 1, datapath accepts the current beat.
- data_out, out, W, angle constant for the current beat.
- iter_idx, out, IDXW, shift amount i for the current beat.
- out_last, out, 1, current beat is the final one of the sequence.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all outputs 0 (data_out=0, iter_idx=0, out_valid=0, out_last=0, busy=0, done=0).
- States: IDLE, FETCH, PRESENT, FINISH.
- IDLE: on start=1, latch mode; set i=0 (circular) or i=1 (hyperbolic); clear rep_done; go to FETCH.
- FETCH: registered ROM read of table[mode][i]; go to PRESENT. First out_valid is asserted 2 cycles after start.
- PRESENT:
  - out_valid=1; data_out and iter_idx are stable until accepted.
  - On out_valid&&out_ready with out_last=0, compute the next index, then go to FETCH. The sustained rate is therefore 1 beat per 2 cycles. This is an accepted cost of the registered ROM.
  - On out_valid&&out_ready with out_last=1, go to FINISH.
- FINISH: done=1 for one cycle; go to IDLE.
- Next-index rule, circular: i+1.
- Next-index rule, hyperbolic:
  - If i is 4 or 13 and rep_done=0: keep i and set rep_done=1.
  - Otherwise: i+1 and clear rep_done.
  - The repeat indices are 4 and 13 only; 40 is beyond the 32-entry table.
- out_last:
  - Circular: i==ITERS-1.
  - Hyperbolic: i==ITERS-1 and no repeat is still pending at that i.
- Beat counts:
  - Circular: ITERS beats.
  - Hyperbolic: ITERS-1 beats plus one for each repeat index that is ≤ ITERS-1.
  - With ITERS=32: 32 circular beats, 33 hyperbolic beats.
- Table contents:
  - Circular W=64 values are bit-identical to the existing double table. Examples: i=0 → 3fe921fb54442d18, i=1 → 3fddac670561bb4f, i=31 → 3e00000000000000.
  - Circular W=32: i=0 → 3f490fdb. Index 0 of the hyperbolic table is unused.
  - All other entries are the IEEE value rounded to nearest-even, generated from the package constants.
- start while busy: ignored.
- abort: has priority over every transition. Next cycle: IDLE, out_valid=0, done is not pulsed.
- start and abort together in IDLE: abort wins and the start is dropped.
- rst low mid-sequence: immediate return to IDLE with reset values; no done pulse.
- out_ready held low: the beat is held indefinitely with no change to the outputs.

Decomposition:
- Package cordic_lut_pkg:
  - The four tables: ATAN_D[32], ATAN_S[32], ATANH_D[32], ATANH_S[32].
  - State encoding, HYP_REP0=4 and HYP_REP1=13, and the mode constants MODE_CIRC and MODE_HYP.
- Sub-module cordic_angle_rom:
  - Inputs: clk, en, mode, addr.
  - Output: registered data; selects the table by W.
  - Holds its last value when en=0. The reset-to-zero is done in the parent's output register, not in the ROM.
- The parent module holds the FSM, the index counter, the repeat flag and the handshake.

Test Plan:
- W=64, mode=0, start, out_ready=1 → 32 beats with iter_idx 0..31. data_out is 3fe921fb54442d18 first and 3e00000000000000 last. out_last only on beat 32; done pulses one cycle later.
- W=64, mode=1, out_ready=1 → 33 beats with iter_idx sequence 1,2,3,4,4,5..13,13,14..31. Both beats at 4 carry identical data_out. done follows the last beat.
- W=32, mode=0, out_ready toggling randomly → beat 1 is 3f490fdb. Each beat is held stable while out_ready=0. No beat is duplicated or skipped, and the beat count is 32.
- Abort asserted on the 5th beat while out_valid=1 → next cycle IDLE, out_valid=0, busy=0, no done. A new start afterwards restarts from iter_idx 0.
- rst asserted asynchronously mid-FETCH → all outputs 0 immediately, independent of clk. Normal operation resumes after release.
- start pulsed while busy, and start+abort together in IDLE → both ignored: the sequence and beat count are unchanged and busy stays 0 respectively.
